// File: rtl/move_entry_capture.sv
// Enter-key conditioner for the move game: synchronizes and debounces the
// active-low key, samples the move switches once per press, offers valid/ready.
module move_entry_capture #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MIN_MOVE        = 1,
    parameter int MAX_MOVE        = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_n,
    input  logic [3:0] sw,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [3:0] move_data,
    output logic       bad_move,
    output logic       overrun,
    output logic       key_held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] MIN_V = 5'(MIN_MOVE);
    localparam logic [4:0] MAX_V = 5'(MAX_MOVE);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic [3:0]             data_q, data_d;
    logic                   bad_q, bad_d;
    logic                   ovr_q, ovr_d;
    logic                   held_q, held_d;
    logic                   key_s;
    logic                   capture;
    logic                   legal;

    // Sync chain idles at 1 so reset looks like a released key
    assign key_s = ~sync_q[SYNC_STAGES-1];
    assign legal = ({1'b0, sw} >= MIN_V) && ({1'b0, sw} <= MAX_V);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], key_n};
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q & ~move_ready;
        data_d  = data_q;
        bad_d   = 1'b0;
        ovr_d   = 1'b0;
        held_d  = held_q;
        capture = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!key_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    held_d  = 1'b1;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d = REL_DB;
                    cnt_d   = '0;
                end
            end
            REL_DB: begin
                if (key_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    held_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A legal capture may overlap a transfer; otherwise a pending move wins
        if (capture) begin
            if (!legal) begin
                bad_d = 1'b1;
            end else if (!valid_q || move_ready) begin
                data_d  = sw;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 4'd0;
            bad_q   <= 1'b0;
            ovr_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            bad_q   <= bad_d;
            ovr_q   <= ovr_d;
            held_q  <= held_d;
        end
    end

    assign move_valid = valid_q;
    assign move_data  = data_q;
    assign bad_move   = bad_q;
    assign overrun    = ovr_q;
    assign key_held   = held_q;

endmodule

// File: tb/tb_move_entry_capture.sv
// Directed bench for move_entry_capture with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// MIN_MOVE=1, MAX_MOVE=12.
module tb_move_entry_capture;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_n;
    logic [3:0] sw;
    logic       move_ready;
    logic       move_valid;
    logic [3:0] move_data;
    logic       bad_move;
    logic       overrun;
    logic       key_held;

    int n_cmp = 0;
    int n_err = 0;
    int vrise = 0;
    int hrise = 0;
    int hfall = 0;
    int nbad  = 0;
    int novr  = 0;
    logic pv = 1'b0;
    logic ph = 1'b0;
    int v0, h0, f0, b0, o0;

    move_entry_capture #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .MIN_MOVE       (1),
        .MAX_MOVE       (12)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_n),
        .sw        (sw),
        .move_ready(move_ready),
        .move_valid(move_valid),
        .move_data (move_data),
        .bad_move  (bad_move),
        .overrun   (overrun),
        .key_held  (key_held)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        if (move_valid && !pv) vrise++;
        if (key_held && !ph) hrise++;
        if (!key_held && ph) hfall++;
        if (bad_move) nbad++;
        if (overrun) novr++;
        pv = move_valid;
        ph = key_held;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        v0 = vrise; h0 = hrise; f0 = hfall; b0 = nbad; o0 = novr;
    endtask

    initial begin
        reset = 1'b1; key_n = 1'b1; sw = 4'd0; move_ready = 1'b0;
        steps(3);
        reset = 1'b0;
        step();
        chk("rst_valid", move_valid, 0);
        chk("rst_data", move_data, 0);
        chk("rst_bad", bad_move, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_held", key_held, 0);

        // Basic press: capture lands on the 7th edge
        sw = 4'd3; key_n = 1'b0;
        steps(6);
        chk("lat_before", move_valid, 0);
        step();
        chk("lat_valid", move_valid, 1);
        chk("lat_data", move_data, 3);
        chk("lat_held", key_held, 1);
        sw = 4'd9;
        steps(3);
        chk("hold_valid", move_valid, 1);
        chk("hold_data", move_data, 3);
        key_n = 1'b1; move_ready = 1'b1;
        step();
        chk("xfer_valid", move_valid, 0);
        move_ready = 1'b0;
        steps(5);
        chk("rel_held_still", key_held, 1);
        step();
        chk("rel_held_fall", key_held, 0);

        // Short glitch: no capture, no pulses
        snap();
        key_n = 1'b0; sw = 4'd4;
        steps(3);
        key_n = 1'b1;
        steps(12);
        chk("gl_vrise", vrise - v0, 0);
        chk("gl_hrise", hrise - h0, 0);
        chk("gl_bad", nbad - b0, 0);
        chk("gl_ovr", novr - o0, 0);

        // Out-of-range low (0) and high (13)
        sw = 4'd0; key_n = 1'b0;
        steps(6);
        chk("bad0_before", bad_move, 0);
        step();
        chk("bad0_pulse", bad_move, 1);
        chk("bad0_valid", move_valid, 0);
        step();
        chk("bad0_end", bad_move, 0);
        key_n = 1'b1;
        steps(8);
        sw = 4'd13; key_n = 1'b0;
        steps(7);
        chk("bad13_pulse", bad_move, 1);
        chk("bad13_valid", move_valid, 0);
        key_n = 1'b1;
        steps(8);

        // Overrun: pending 2 survives press of 5
        sw = 4'd2; key_n = 1'b0;
        steps(7);
        chk("ov_first", move_data, 2);
        key_n = 1'b1;
        steps(8);
        sw = 4'd5; key_n = 1'b0;
        steps(7);
        chk("ov_pulse", overrun, 1);
        chk("ov_data", move_data, 2);
        chk("ov_valid", move_valid, 1);
        step();
        chk("ov_end", overrun, 0);
        key_n = 1'b1;
        steps(8);

        // Ready on the capture cycle: replacement, no overrun
        sw = 4'd5; key_n = 1'b0;
        steps(6);
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        chk("rc_valid", move_valid, 1);
        chk("rc_data", move_data, 5);
        chk("rc_ovr", overrun, 0);
        step();
        chk("rc_keep", move_valid, 1);
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        chk("rc_xfer", move_valid, 0);
        key_n = 1'b1;
        steps(8);

        // Bounce around press and release
        snap();
        sw = 4'd12;
        for (int i = 0; i < 6; i++) begin
            key_n = i[0];
            step();
        end
        key_n = 1'b0;
        steps(15);
        chk("bn_data", move_data, 12);
        for (int i = 0; i < 6; i++) begin
            key_n = ~i[0];
            step();
        end
        key_n = 1'b1;
        steps(15);
        chk("bn_vrise", vrise - v0, 1);
        chk("bn_hrise", hrise - h0, 1);
        chk("bn_hfall", hfall - f0, 1);
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        chk("bn_xfer", move_valid, 0);

        // Reset during press debounce with key still held
        sw = 4'd7; key_n = 1'b0;
        steps(4);
        reset = 1'b1;
        step();
        chk("mr_valid", move_valid, 0);
        chk("mr_held", key_held, 0);
        step();
        reset = 1'b0;
        steps(6);
        chk("mr_before", move_valid, 0);
        step();
        chk("mr_valid2", move_valid, 1);
        chk("mr_data", move_data, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
